// File: rtl/sram_1w1r_sync.sv
// sram_1w1r_sync: one write port and one read port on a single clock, with
// per-lane write masking, optional same-address write-to-read forwarding,
// a 1- or 2-cycle registered read path, and a self-sequencing array clear
// that runs after reset and on request.
module sram_1w1r_sync #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 11,
  parameter int WMASK_GRAN   = 2,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                               clk0,
  input  logic                               rstb,
  input  logic                               csb0,
  input  logic [DATA_WIDTH/WMASK_GRAN-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  input  logic                               clr,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               dout1_valid,
  output logic                               busy
);

  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("DATA_WIDTH must be a multiple of WMASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       clr_cnt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   rd_accept;

  assign busy      = (state == CLEAR);
  assign rd_accept = (state == RUN) && !csb1;

  // Clear sequencer: walk every address once, then serve the ports.
  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Array writes: zero-fill while clearing, masked lane writes while running.
  always_ff @(posedge clk0) begin
    if (state == CLEAR) begin
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (!csb0) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*WMASK_GRAN +: WMASK_GRAN] <= din0[i*WMASK_GRAN +: WMASK_GRAN];
        end
      end
    end
  end

  // Read word at accept time; optionally forward same-edge written lanes.
  always_comb begin
    rd_word = mem[addr1];
    if (BYPASS != 0 && state == RUN && !csb0 && addr0 == addr1) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          rd_word[i*WMASK_GRAN +: WMASK_GRAN] = din0[i*WMASK_GRAN +: WMASK_GRAN];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_valid;

    // Two-stage read path; data is captured at accept so later writes cannot disturb it.
    always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
        pipe_data   <= '0;
        pipe_valid  <= 1'b0;
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        pipe_valid  <= rd_accept;
        if (rd_accept) pipe_data <= rd_word;
        dout1_valid <= pipe_valid;
        if (pipe_valid) dout1 <= pipe_data;
      end
    end
  end else begin : g_lat1
    // Single-stage read path; dout1 holds its value when no read completes.
    always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        dout1_valid <= rd_accept;
        if (rd_accept) dout1 <= rd_word;
      end
    end
  end

endmodule

// File: doc/sram_1w1r_sync.md
SRAM_1W1R_SYNC -- requirements
Module: sram_1w1r_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per word.
REQ-002 Parameter ADDR_WIDTH, default 11, address bits; depth = 2**ADDR_WIDTH.
REQ-003 Parameter WMASK_GRAN, default 2, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN; DATA_WIDTH not a multiple of WMASK_GRAN is an elaboration error.
REQ-004 Parameter READ_LATENCY, default 1, legal 1 or 2, posedges from read accept to dout1 valid.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle same-address write forwarded to read, 0 = read returns pre-write data.
REQ-006 clk0  input  1  single clock; all state changes on posedge.
REQ-007 rstb  input  1  reset, asynchronous assert, active-low.
REQ-008 csb0  input  1  write port chip select, active-low.
REQ-009 wmask0  input  NUM_WMASKS  per-lane write enable, bit i covers din0[i*WMASK_GRAN +: WMASK_GRAN].
REQ-010 addr0  input  ADDR_WIDTH  write address.
REQ-011 din0  input  DATA_WIDTH  write data.
REQ-012 csb1  input  1  read port chip select, active-low.
REQ-013 addr1  input  ADDR_WIDTH  read address.
REQ-014 clr  input  1  request full-array clear, sampled at posedge.
REQ-015 dout1  output  DATA_WIDTH  read data, registered.
REQ-016 dout1_valid  output  1  one-cycle pulse, dout1 carries a new read result.
REQ-017 busy  output  1  high while clearing; ports ignored.

Function
REQ-018 FSM states CLEAR and RUN; clear counter ADDR_WIDTH+1 bits.
REQ-019 CLEAR: each posedge writes all-zero to mem[counter], counter increments; after writing address depth-1, next state RUN, counter returns to 0.
REQ-020 busy = 1 in CLEAR, 0 in RUN; clear takes exactly depth posedges.
REQ-021 RUN with clr=1 at posedge: next state CLEAR, counter 0; any csb0/csb1 activity on that edge is still executed.
REQ-022 clr while in CLEAR: ignored, no restart.
REQ-023 While busy=1: csb0/csb1 ignored, no write, no dout1_valid pulse.
REQ-024 Write accept (RUN, csb0=0): at that posedge lanes with wmask0[i]=1 take din0 lane; lanes with 0 unchanged; wmask0 all-zero = no change.
REQ-025 Read accept (RUN, csb1=0): data for mem[addr1] appears on dout1 with dout1_valid=1 exactly READ_LATENCY posedges after accept.
REQ-026 Back-to-back reads every cycle: one result per cycle, in order, no bubbles.
REQ-027 Same-cycle write and read, addr0==addr1, BYPASS=1: result = per-lane merge, masked lanes from din0, others from stored word.
REQ-028 Same case, BYPASS=0: result = stored word before the write.
REQ-029 Different addresses on the same edge: independent, both complete.
REQ-030 READ_LATENCY=2: write on the edge following a read accept to the same address does not alter that read's result.
REQ-031 No read result: dout1 holds last value, dout1_valid=0.
REQ-032 Read accepted on the same edge as clr: result from pre-clear array; pipeline drains normally while busy.

Reset
REQ-033 rstb=0 asynchronously forces: state CLEAR, counter 0, busy=1, dout1=0, dout1_valid=0, read pipeline valid bits 0.
REQ-034 Array contents unspecified during reset; CLEAR starts on the first posedge after rstb rises.
REQ-035 Reset mid-CLEAR or mid-read: clear restarts at address 0; in-flight reads discarded, no valid pulse.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, WMASK_GRAN=2)
REQ-036 Release reset -> busy=1 for 16 posedges, then 0; reads of all addresses return 0x00.
REQ-037 Write addr 3 din 0xA5 wmask 0xF, then read addr 3 -> dout1=0xA5, valid after READ_LATENCY posedges.
REQ-038 Addr 3 holds 0xA5; write din 0x3C wmask 0b0101 and read addr 3 same edge -> BYPASS=1: 0xB4; BYPASS=0: 0xA5; later read 0xB4.
REQ-039 Reads addr 0,1,2 on consecutive edges, pre-written 0x11,0x22,0x33 -> three consecutive valid cycles 0x11,0x22,0x33.
REQ-040 clr pulse in RUN, csb0=0 during busy -> no write lands; after 16 cycles every address reads 0x00.
REQ-041 rstb low at clear address 7 -> busy stays 1, next clear runs full 16 cycles from address 0.
